// File: rtl/time_tag_latch_pkg.sv
// Shared definitions for the time-tag latch: default widths, the readout
// state encoding, the snapshot word indices and a word-index helper.
package time_tag_latch_pkg;

  localparam int CNT_W_DEF  = 32;
  localparam int DROP_W_DEF = 8;

  // Readout state: EMPTY waits for a trigger, FULL holds a snapshot
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } tag_state_e;

  // Order in which the snapshot words are presented to the output mux
  typedef enum logic [1:0] {
    W_SEC  = 2'd0,
    W_CYC  = 2'd1,
    W_PPS  = 2'd2,
    W_PREV = 2'd3
  } tag_word_e;

  // Index of the word presented after the current one (wraps to W_SEC)
  function automatic logic [1:0] next_word(input logic [1:0] sel);
    logic [1:0] nxt;
    if (sel == W_PREV) begin
      nxt = W_SEC;
    end else begin
      nxt = sel + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/time_tag_latch_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// A pin edge shows up as a one-cycle pulse three clocks later; a level held
// high yields exactly one pulse.
// Ports:
//   clk   - sampling clock
//   reset - asynchronous, active-high reset
//   din   - asynchronous input pin
//   pulse - one-cycle pulse on each synchronised rising edge
module time_tag_latch_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchroniser chain, history stage and registered edge pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
      pulse  <= sync_r & ~prev_r;
    end
  end

endmodule

// File: rtl/time_tag_latch.sv
// Time-tagging front end. Counts clk cycles between PPS edges, keeps a GPS
// second counter and, on a trigger edge, snapshots four words for readout
// through an external 4:1 mux selected by tag_sel.
// Ports:
//   clk        - system clock
//   reset      - asynchronous, active-high reset
//   pps_in     - 1PPS pin, asynchronous to clk
//   trig_in    - trigger pin, asynchronous, rising-edge active
//   sec_in     - second preset value
//   sec_load   - one-cycle strobe loading sec_in into the second counter
//   rd_next    - one-cycle strobe: current word consumed, advance
//   tag_sec    - word 0: second count at trigger
//   tag_cyc    - word 1: cycles since last PPS at trigger
//   tag_pps    - word 2: length of last full PPS second
//   tag_prev   - word 3: length of the PPS second before that
//   tag_sel    - word index for the readout mux
//   tag_valid  - snapshot held, readout in progress
//   drop_cnt   - triggers lost while a snapshot was held (saturating)
module time_tag_latch
  import time_tag_latch_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pps_in,
  input  logic              trig_in,
  input  logic [CNT_W-1:0]  sec_in,
  input  logic              sec_load,
  input  logic              rd_next,
  output logic [CNT_W-1:0]  tag_sec,
  output logic [CNT_W-1:0]  tag_cyc,
  output logic [CNT_W-1:0]  tag_pps,
  output logic [CNT_W-1:0]  tag_prev,
  output logic [1:0]        tag_sel,
  output logic              tag_valid,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [DROP_W-1:0] DROP_ZERO = {DROP_W{1'b0}};
  localparam logic [DROP_W-1:0] DROP_ONE  = {{(DROP_W-1){1'b0}}, 1'b1};
  localparam logic [DROP_W-1:0] DROP_MAX  = {DROP_W{1'b1}};

  // Saturating increment for the dropped-trigger counter
  function automatic logic [DROP_W-1:0] drop_sat_inc(input logic [DROP_W-1:0] v);
    logic [DROP_W-1:0] r;
    if (v == DROP_MAX) begin
      r = v;
    end else begin
      r = v + DROP_ONE;
    end
    return r;
  endfunction

  logic             pps_re_s;
  logic             trig_re_s;
  logic [CNT_W-1:0] cyc_cnt_r;
  logic [CNT_W-1:0] sec_cnt_r;
  logic [CNT_W-1:0] pps_len_r;
  logic [CNT_W-1:0] prev_len_r;
  tag_state_e       state_r;
  tag_state_e       state_nxt_s;
  logic [1:0]       sel_nxt_s;
  logic             valid_nxt_s;
  logic             capture_s;
  logic             drop_inc_s;

  time_tag_latch_sync_edge u_pps_sync (
    .clk   (clk),
    .reset (reset),
    .din   (pps_in),
    .pulse (pps_re_s)
  );

  time_tag_latch_sync_edge u_trig_sync (
    .clk   (clk),
    .reset (reset),
    .din   (trig_in),
    .pulse (trig_re_s)
  );

  // Cycle counter and PPS period history; the counter sticks at all-ones
  // if PPS goes missing so a stale value is never mistaken for a fresh one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt_r  <= CNT_ZERO;
      pps_len_r  <= CNT_ZERO;
      prev_len_r <= CNT_ZERO;
    end else if (pps_re_s) begin
      cyc_cnt_r  <= CNT_ZERO;
      pps_len_r  <= cyc_cnt_r + CNT_ONE;
      prev_len_r <= pps_len_r;
    end else if (cyc_cnt_r != CNT_MAX) begin
      cyc_cnt_r  <= cyc_cnt_r + CNT_ONE;
      pps_len_r  <= pps_len_r;
      prev_len_r <= prev_len_r;
    end else begin
      cyc_cnt_r  <= cyc_cnt_r;
      pps_len_r  <= pps_len_r;
      prev_len_r <= prev_len_r;
    end
  end

  // GPS second counter: a software preset beats a coincident PPS increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_cnt_r <= CNT_ZERO;
    end else if (sec_load) begin
      sec_cnt_r <= sec_in;
    end else if (pps_re_s) begin
      sec_cnt_r <= sec_cnt_r + CNT_ONE;
    end else begin
      sec_cnt_r <= sec_cnt_r;
    end
  end

  // Readout FSM next-state logic; a trigger while FULL is counted as dropped,
  // including on the cycle that consumes the last word
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = tag_sel;
    valid_nxt_s = tag_valid;
    capture_s   = 1'b0;
    drop_inc_s  = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (trig_re_s) begin
          state_nxt_s = ST_FULL;
          sel_nxt_s   = W_SEC;
          valid_nxt_s = 1'b1;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        drop_inc_s = trig_re_s;
        if (rd_next) begin
          sel_nxt_s = next_word(tag_sel);
          if (tag_sel == W_PREV) begin
            state_nxt_s = ST_EMPTY;
            valid_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
        sel_nxt_s   = W_SEC;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Readout FSM state, word select and valid flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_EMPTY;
      tag_sel   <= W_SEC;
      tag_valid <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      tag_sel   <= sel_nxt_s;
      tag_valid <= valid_nxt_s;
    end
  end

  // Snapshot of the pre-update counter values; held until the next capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_sec  <= CNT_ZERO;
      tag_cyc  <= CNT_ZERO;
      tag_pps  <= CNT_ZERO;
      tag_prev <= CNT_ZERO;
    end else if (capture_s) begin
      tag_sec  <= sec_cnt_r;
      tag_cyc  <= cyc_cnt_r;
      tag_pps  <= pps_len_r;
      tag_prev <= prev_len_r;
    end else begin
      tag_sec  <= tag_sec;
      tag_cyc  <= tag_cyc;
      tag_pps  <= tag_pps;
      tag_prev <= tag_prev;
    end
  end

  // Dropped-trigger counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= DROP_ZERO;
    end else if (drop_inc_s) begin
      drop_cnt <= drop_sat_inc(drop_cnt);
    end else begin
      drop_cnt <= drop_cnt;
    end
  end

endmodule

// File: tb/tb_time_tag_latch.sv
// Self-checking bench for time_tag_latch. A second instance built with
// 8-bit counters covers cycle-counter saturation.
module tb_time_tag_latch;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        pps_in   = 1'b0;
  logic        trig_in  = 1'b0;
  logic        sec_load = 1'b0;
  logic        rd_next  = 1'b0;
  logic [31:0] sec_in   = 32'd0;

  logic [31:0] tag_sec, tag_cyc, tag_pps, tag_prev;
  logic [1:0]  tag_sel;
  logic        tag_valid;
  logic [7:0]  drop_cnt;

  logic [7:0]  s8_sec, s8_cyc, s8_pps, s8_prev;
  logic [1:0]  s8_sel;
  logic        s8_valid;
  logic [7:0]  s8_drop;

  int checks   = 0;
  int failures = 0;

  time_tag_latch dut (
    .clk(clk), .reset(reset), .pps_in(pps_in), .trig_in(trig_in),
    .sec_in(sec_in), .sec_load(sec_load), .rd_next(rd_next),
    .tag_sec(tag_sec), .tag_cyc(tag_cyc), .tag_pps(tag_pps), .tag_prev(tag_prev),
    .tag_sel(tag_sel), .tag_valid(tag_valid), .drop_cnt(drop_cnt)
  );

  time_tag_latch #(.CNT_W(8), .DROP_W(8)) dut8 (
    .clk(clk), .reset(reset), .pps_in(pps_in), .trig_in(trig_in),
    .sec_in(sec_in[7:0]), .sec_load(sec_load), .rd_next(rd_next),
    .tag_sec(s8_sec), .tag_cyc(s8_cyc), .tag_pps(s8_pps), .tag_prev(s8_prev),
    .tag_sel(s8_sel), .tag_valid(s8_valid), .drop_cnt(s8_drop)
  );

  always #5 clk = ~clk;

  // Edge number: the rising edge that makes ecount == N is edge N
  int unsigned ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  // Edges at which a synchronised PPS / trigger pulse takes effect
  bit pps_at  [int unsigned];
  bit trig_at [int unsigned];

  // Reference model: time since PPS comes from edge-number arithmetic
  logic [31:0] m_sec, m_len, m_prev, m_tsec, m_tcyc, m_tpps, m_tprev;
  logic [1:0]  m_sel;
  logic        m_full;
  logic [7:0]  m_drop;
  longint      m_last;

  always @(posedge clk or posedge reset) begin : model
    int unsigned cur;
    longint      cyc;
    logic [31:0] cyc32;
    bit          p, t;
    cur = ecount + 1;
    if (reset) begin
      m_sec <= 32'd0; m_len <= 32'd0; m_prev <= 32'd0;
      m_tsec <= 32'd0; m_tcyc <= 32'd0; m_tpps <= 32'd0; m_tprev <= 32'd0;
      m_sel <= 2'd0; m_full <= 1'b0; m_drop <= 8'd0;
      m_last <= longint'(cur);
    end else begin
      cyc = longint'(cur) - m_last - 1;
      cyc32 = (cyc > 64'sh0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : cyc[31:0];
      p = pps_at.exists(cur);
      t = trig_at.exists(cur);
      if (!m_full) begin
        if (t) begin
          m_full <= 1'b1; m_sel <= 2'd0;
          m_tsec <= m_sec; m_tcyc <= cyc32; m_tpps <= m_len; m_tprev <= m_prev;
        end
      end else begin
        if (t && m_drop != 8'hFF) m_drop <= m_drop + 8'd1;
        if (rd_next) begin
          if (m_sel == 2'd3) begin m_full <= 1'b0; m_sel <= 2'd0; end
          else m_sel <= m_sel + 2'd1;
        end
      end
      if (p) begin m_len <= cyc32 + 32'd1; m_prev <= m_len; m_last <= longint'(cur); end
      if (sec_load) m_sec <= sec_in;
      else if (p) m_sec <= m_sec + 32'd1;
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_pps();
    pps_in = 1'b1; pps_at[ecount + 4] = 1'b1; step(1); pps_in = 1'b0;
  endtask

  task automatic pulse_trig();
    trig_in = 1'b1; trig_at[ecount + 4] = 1'b1; step(1); trig_in = 1'b0;
  endtask

  task automatic rd_pulse();
    rd_next = 1'b1; step(1); rd_next = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 12 && tag_valid !== 1'b1; i++) step(1);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && tag_valid === 1'b1; i++) rd_pulse();
    step(1);
  endtask

  task automatic do_reset(output int unsigned rel);
    reset = 1'b1; pps_in = 1'b0; trig_in = 1'b0; rd_next = 1'b0; sec_load = 1'b0;
    pps_at.delete(); trig_at.delete();
    step(3);
    reset = 1'b0; rel = ecount;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int unsigned rel, b;
    reset = 1'b1; pps_at.delete(); trig_at.delete();
    for (int i = 0; i < 10; i++) begin
      pps_in = 1'($urandom_range(0, 1)); trig_in = 1'($urandom_range(0, 1));
      rd_next = 1'($urandom_range(0, 1)); sec_load = 1'($urandom_range(0, 1));
      sec_in = $urandom; step(1);
    end
    checks++;
    if ({tag_sec, tag_cyc, tag_pps, tag_prev, tag_sel, tag_valid, drop_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got sec=%h cyc=%h pps=%h prev=%h sel=%0d valid=%b drop=%0d, want all 0",
               tag_sec, tag_cyc, tag_pps, tag_prev, tag_sel, tag_valid, drop_cnt);
    end
    checks++;
    if ({s8_sec, s8_cyc, s8_pps, s8_prev, s8_sel, s8_valid, s8_drop} !== '0) begin
      failures++;
      $display("FAIL reset_outputs8: got sec=%h cyc=%h pps=%h prev=%h sel=%0d valid=%b drop=%0d, want all 0",
               s8_sec, s8_cyc, s8_pps, s8_prev, s8_sel, s8_valid, s8_drop);
    end
    pps_in = 1'b0; trig_in = 1'b0; rd_next = 1'b0; sec_load = 1'b0;
    step(2);
    reset = 1'b0; rel = ecount;
    step(5);
    b = ecount; pulse_trig(); wait_valid();
    checks++;
    if (tag_valid !== 1'b1) begin
      failures++; $display("FAIL reset_first_trig_valid: got %b want 1", tag_valid);
    end
    // trigger acts on edge b+4; first counting edge after release is rel+1
    checks++;
    if (tag_cyc !== 32'(b + 3 - rel)) begin
      failures++; $display("FAIL reset_cyc_from_zero: got %0d want %0d", tag_cyc, b + 3 - rel);
    end
    checks++;
    if ({tag_sec, tag_pps, tag_prev, tag_sel} !== '0) begin
      failures++;
      $display("FAIL reset_first_words: got sec=%h pps=%h prev=%h sel=%0d want 0", tag_sec, tag_pps, tag_prev, tag_sel);
    end
    drain();
  endtask

  task automatic test_pps_period();
    localparam int P = 1000;
    pulse_pps(); step(P - 1);
    pulse_pps(); step(P - 1);
    pulse_pps(); step(20);
    pulse_trig(); wait_valid();
    checks++;
    if (tag_pps !== 32'(P) || tag_prev !== 32'(P) || tag_sec !== 32'd3) begin
      failures++;
      $display("FAIL pps_period: got pps=%0d prev=%0d sec=%0d want %0d %0d 3", tag_pps, tag_prev, tag_sec, P, P);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tag_sel !== 2'(k) || tag_valid !== 1'b1) begin
        failures++; $display("FAIL readout_sel: got sel=%0d valid=%b want sel=%0d valid=1", tag_sel, tag_valid, k);
      end
      rd_pulse();
    end
    checks++;
    if (tag_sel !== 2'd0 || tag_valid !== 1'b0 || tag_pps !== 32'(P)) begin
      failures++;
      $display("FAIL readout_done: got sel=%0d valid=%b pps=%0d want sel=0 valid=0 pps=%0d", tag_sel, tag_valid, tag_pps, P);
    end
    step(1);
  endtask

  task automatic test_sec_load();
    logic [31:0] v;
    int n;
    // load sampled on the same edge the PPS pulse acts on
    pulse_pps(); step(2);
    sec_in = 32'h5000_0000; sec_load = 1'b1; step(1); sec_load = 1'b0;
    step(10); pulse_trig(); wait_valid();
    checks++;
    if (tag_sec !== 32'h5000_0000) begin
      failures++; $display("FAIL sec_load_vs_pps: got %h want 50000000", tag_sec);
    end
    drain();
    v = $urandom; n = $urandom_range(1, 3);
    sec_in = v; sec_load = 1'b1; step(1); sec_load = 1'b0;
    repeat (n) begin step(20); pulse_pps(); end
    step(10); pulse_trig(); wait_valid();
    checks++;
    if (tag_sec !== v + 32'(n) || tag_sec !== m_tsec) begin
      failures++; $display("FAIL sec_load_count: got %h want %h", tag_sec, v + 32'(n));
    end
    drain();
  endtask

  task automatic test_trigger_offset();
    int d;
    for (int it = 0; it < 4; it++) begin
      d = (it == 0) ? 251 : int'($urandom_range(1, 700));
      pulse_pps(); step(d - 1); pulse_trig(); wait_valid();
      // cyc_cnt reads 0 on the cycle after pps_re, so d cycles later it reads d-1
      checks++;
      if (tag_cyc !== 32'(d - 1) || tag_valid !== 1'b1 || tag_sel !== 2'd0) begin
        failures++;
        $display("FAIL trig_offset d=%0d: got cyc=%0d valid=%b sel=%0d want cyc=%0d valid=1 sel=0",
                 d, tag_cyc, tag_valid, tag_sel, d - 1);
      end
      checks++;
      if ({tag_sec, tag_pps, tag_prev} !== {m_tsec, m_tpps, m_tprev}) begin
        failures++;
        $display("FAIL trig_words: got sec=%h pps=%0d prev=%0d want sec=%h pps=%0d prev=%0d",
                 tag_sec, tag_pps, tag_prev, m_tsec, m_tpps, m_tprev);
      end
      drain();
    end
  endtask

  task automatic test_drop();
    pulse_trig(); wait_valid();
    step(3); pulse_trig(); step(6);
    checks++;
    if (drop_cnt !== 8'd1 || tag_valid !== 1'b1) begin
      failures++; $display("FAIL drop_while_full: got drop=%0d valid=%b want 1 1", drop_cnt, tag_valid);
    end
    checks++;
    if ({tag_sec, tag_cyc, tag_pps, tag_prev} !== {m_tsec, m_tcyc, m_tpps, m_tprev}) begin
      failures++;
      $display("FAIL drop_words_stable: got %h %h %h %h want %h %h %h %h",
               tag_sec, tag_cyc, tag_pps, tag_prev, m_tsec, m_tcyc, m_tpps, m_tprev);
    end
    rd_pulse(); rd_pulse(); rd_pulse();
    // trigger acts on the same edge as the final rd_next
    trig_in = 1'b1; trig_at[ecount + 4] = 1'b1; step(1); trig_in = 1'b0;
    step(2); rd_next = 1'b1; step(1); rd_next = 1'b0; step(5);
    checks++;
    if (drop_cnt !== 8'd2 || tag_valid !== 1'b0 || tag_sel !== 2'd0) begin
      failures++;
      $display("FAIL drop_on_final_rd: got drop=%0d valid=%b sel=%0d want 2 0 0", drop_cnt, tag_valid, tag_sel);
    end
    pulse_trig(); wait_valid();
    rd_pulse(); rd_pulse(); rd_pulse();
    // trigger acts one edge after the final rd_next
    trig_in = 1'b1; trig_at[ecount + 4] = 1'b1; step(1); trig_in = 1'b0;
    step(1); rd_next = 1'b1; step(1); rd_next = 1'b0; step(3);
    checks++;
    if (tag_valid !== 1'b1 || drop_cnt !== 8'd2 || tag_sel !== 2'd0 || tag_cyc !== m_tcyc) begin
      failures++;
      $display("FAIL capture_after_final_rd: got valid=%b drop=%0d sel=%0d cyc=%0d want 1 2 0 %0d",
               tag_valid, drop_cnt, tag_sel, tag_cyc, m_tcyc);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int unsigned rel;
    logic t_prev, p_prev, t_new, p_new;
    int bad;
    do_reset(rel);
    t_prev = 1'b0; p_prev = 1'b0; bad = 0;
    for (int c = 0; c < 400; c++) begin
      t_new = ($urandom_range(0, 3) == 0);
      p_new = ($urandom_range(0, 59) == 0);
      if (t_new && !t_prev) trig_at[ecount + 4] = 1'b1;
      if (p_new && !p_prev) pps_at[ecount + 4] = 1'b1;
      trig_in = t_new; pps_in = p_new; t_prev = t_new; p_prev = p_new;
      rd_next = 1'($urandom_range(0, 1));
      sec_load = ($urandom_range(0, 39) == 0);
      sec_in = $urandom;
      step(1);
      checks++;
      if ({tag_sec, tag_cyc, tag_pps, tag_prev, tag_sel, tag_valid, drop_cnt} !==
          {m_tsec, m_tcyc, m_tpps, m_tprev, m_sel, m_full, m_drop}) begin
        failures++; bad++;
        if (bad <= 5)
          $display("FAIL b2b cycle %0d: got sec=%h cyc=%0d pps=%0d prev=%0d sel=%0d valid=%b drop=%0d want sec=%h cyc=%0d pps=%0d prev=%0d sel=%0d valid=%b drop=%0d",
                   c, tag_sec, tag_cyc, tag_pps, tag_prev, tag_sel, tag_valid, drop_cnt,
                   m_tsec, m_tcyc, m_tpps, m_tprev, m_sel, m_full, m_drop);
      end
    end
    trig_in = 1'b0; pps_in = 1'b0; rd_next = 1'b0; sec_load = 1'b0;
    step(6);
    drain();
  endtask

  task automatic test_saturation();
    int unsigned rel, b;
    do_reset(rel);
    step(300);
    b = ecount; pulse_trig(); wait_valid();
    checks++;
    if (s8_cyc !== 8'hFF || s8_valid !== 1'b1) begin
      failures++; $display("FAIL cyc_saturate8: got cyc=%0d valid=%b want 255 1", s8_cyc, s8_valid);
    end
    checks++;
    if ({s8_sec, s8_pps, s8_prev, s8_sel} !== '0) begin
      failures++; $display("FAIL sat8_words: got sec=%0d pps=%0d prev=%0d sel=%0d want 0", s8_sec, s8_pps, s8_prev, s8_sel);
    end
    checks++;
    if (tag_cyc !== 32'(b + 3 - rel)) begin
      failures++; $display("FAIL cyc_no_sat32: got %0d want %0d", tag_cyc, b + 3 - rel);
    end
    for (int i = 0; i < 300; i++) begin
      trig_in = 1'b1; trig_at[ecount + 4] = 1'b1; step(1);
      trig_in = 1'b0; step(1);
    end
    step(6);
    checks++;
    if (drop_cnt !== 8'd255 || s8_drop !== 8'd255 || m_drop !== 8'd255) begin
      failures++;
      $display("FAIL drop_saturate: got drop=%0d drop8=%0d want 255", drop_cnt, s8_drop);
    end
    checks++;
    if (tag_valid !== 1'b1 || tag_cyc !== 32'(b + 3 - rel)) begin
      failures++; $display("FAIL sat_words_held: got valid=%b cyc=%0d want 1 %0d", tag_valid, tag_cyc, b + 3 - rel);
    end
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pps_period();
    test_sec_load();
    test_trigger_offset();
    test_drop();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
